sdram_ls_arb: RTL and testbench

Round-robin arbiter and sequencer for the SDRAM controller's load/store (ls) toggle-handshake port.
- Replaces the ad-hoc XOR sharing of that port between the ROM loader and the backup-RAM transfer engine.
- Accepts N independent toggle-handshake requesters and serialises them into single read or write transactions on the ls port.
- Routes each completion back to its requester.
- Sits in pcfx_top between those engines and the sdram instance, in the clk_sys domain.

---
 rtl/sdram_ls_arb.sv | 161 ++++++++++++++++
 tb/tb_sdram_ls_arb.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ls_arb.sv
// Round-robin arbiter that serialises N toggle-handshake requesters onto the SDRAM load/store port.
// Optional watchdog: define LS_ARB_WATCHDOG_EN to abort ls transactions that never complete.
module sdram_ls_arb #(
    parameter int N     = 3,
    parameter int AW    = 25,
    parameter int DW    = 32,
    parameter int TMO_W = 12
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [N-1:0]    m_req,
    input  logic [N-1:0]    m_we,
    input  logic [N*AW-1:0] m_addr,
    input  logic [N*DW-1:0] m_din,
    output logic [N-1:0]    m_ack,
    output logic [DW-1:0]   m_dout,
    output logic [N-1:0]    grant,
    output logic            busy,
    output logic [AW-1:0]   ls_addr,
    output logic [DW-1:0]   ls_din,
    output logic            ls_we_req,
    input  logic            ls_we_ack,
    output logic            ls_rd_req,
    input  logic            ls_rd_ack,
    input  logic [DW-1:0]   ls_dout,
    output logic            tmo_err
);

    localparam int          IW      = $clog2(N);
    localparam logic [N-1:0] ONE_HOT = N'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t         state;
    logic [IW-1:0]  last;
    logic [IW-1:0]  sel_idx;
    logic [IW-1:0]  cand;
    logic           sel_valid;
    logic           wr_flag;
    logic [N-1:0]   pending;
    logic           done;
    logic           wd_fire;

    if (N < 2 || N > 8 || TMO_W < 2) begin : g_param_check
        $error("sdram_ls_arb: N must be 2..8 and TMO_W at least 2");
    end

    assign pending = m_req ^ m_ack;
    assign done    = wr_flag ? (ls_we_ack == ls_we_req) : (ls_rd_ack == ls_rd_req);

    // Walk from the farthest candidate towards last+1 so the nearest pending index wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N);
            if (pending[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

`ifdef LS_ARB_WATCHDOG_EN
    localparam logic [TMO_W-1:0] WD_LAST = ~TMO_W'(1);

    logic [TMO_W-1:0] wd_cnt;

    // Fires on the WAIT edge that would bring the counter to all-ones.
    assign wd_fire = (state == WAIT) && !done && (wd_cnt == WD_LAST);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            tmo_err <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT && !done) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) begin
                tmo_err <= 1'b1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign tmo_err = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            m_ack     <= '0;
            m_dout    <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            ls_addr   <= '0;
            ls_din    <= '0;
            ls_we_req <= 1'b0;
            ls_rd_req <= 1'b0;
            last      <= IW'(N - 1);
            wr_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    grant <= '0;
                    if (sel_valid) begin
                        grant   <= ONE_HOT << sel_idx;
                        last    <= sel_idx;
                        ls_addr <= m_addr[sel_idx*AW +: AW];
                        ls_din  <= m_din[sel_idx*DW +: DW];
                        wr_flag <= m_we[sel_idx];
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr_flag) begin
                        ls_we_req <= ~ls_we_req;
                    end else begin
                        ls_rd_req <= ~ls_rd_req;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        m_ack[last] <= ~m_ack[last];
                        if (!wr_flag) begin
                            m_dout <= ls_dout;
                        end
                        busy  <= 1'b0;
                        grant <= '0;
                        state <= IDLE;
                    end else if (wd_fire) begin
                        // Realign the stuck toggle so a late SDRAM ack cannot be mistaken for a new one.
                        m_ack[last] <= ~m_ack[last];
                        if (wr_flag) begin
                            ls_we_req <= ls_we_ack;
                        end else begin
                            ls_rd_req <= ls_rd_ack;
                        end
                        busy  <= 1'b0;
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_ls_arb.sv
// Directed self-checking bench for sdram_ls_arb with a toggle-handshake SDRAM model of adjustable latency.
module tb_sdram_ls_arb;

    localparam int N     = 3;
    localparam int AW    = 25;
    localparam int DW    = 32;
    localparam int TMO_W = 4;

    logic            clk_sys = 1'b0;
    logic            reset   = 1'b1;
    logic [N-1:0]    m_req   = '0;
    logic [N-1:0]    m_we    = '0;
    logic [N*AW-1:0] m_addr  = '0;
    logic [N*DW-1:0] m_din   = '0;
    logic [N-1:0]    m_ack;
    logic [DW-1:0]   m_dout;
    logic [N-1:0]    grant;
    logic            busy;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_din;
    logic            ls_we_req;
    logic            ls_we_ack;
    logic            ls_rd_req;
    logic            ls_rd_ack;
    logic [DW-1:0]   ls_dout;
    logic            tmo_err;

    int              check_count = 0;
    int              pass_count  = 0;

    sdram_ls_arb #(
        .N(N),
        .AW(AW),
        .DW(DW),
        .TMO_W(TMO_W)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .m_req(m_req),
        .m_we(m_we),
        .m_addr(m_addr),
        .m_din(m_din),
        .m_ack(m_ack),
        .m_dout(m_dout),
        .grant(grant),
        .busy(busy),
        .ls_addr(ls_addr),
        .ls_din(ls_din),
        .ls_we_req(ls_we_req),
        .ls_we_ack(ls_we_ack),
        .ls_rd_req(ls_rd_req),
        .ls_rd_ack(ls_rd_ack),
        .ls_dout(ls_dout),
        .tmo_err(tmo_err)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM model: acks a toggle after lat edges, never acks while noack is set.
    int          lat         = 1;
    bit          noack       = 1'b0;
    logic [DW-1:0] model_rdata = '0;
    int          we_cnt;
    int          rd_cnt;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ls_we_ack <= 1'b0;
            ls_rd_ack <= 1'b0;
            ls_dout   <= '0;
            we_cnt    <= 0;
            rd_cnt    <= 0;
        end else begin
            if (!noack && ls_we_req != ls_we_ack) begin
                if (we_cnt >= lat - 1) begin
                    ls_we_ack <= ls_we_req;
                    we_cnt    <= 0;
                end else begin
                    we_cnt <= we_cnt + 1;
                end
            end
            if (!noack && ls_rd_req != ls_rd_ack) begin
                if (rd_cnt >= lat - 1) begin
                    ls_rd_ack <= ls_rd_req;
                    ls_dout   <= model_rdata;
                    rd_cnt    <= 0;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                end
            end
        end
    end

    // Bus monitor: toggle counts, toggle timestamps and grant sequence.
    int            cycle = 0;
    logic          prev_we = 1'b0;
    logic          prev_rd = 1'b0;
    logic [N-1:0]  prev_grant = '0;
    int            we_toggles = 0;
    int            rd_toggles = 0;
    int            both_toggles = 0;
    int            toggle_cyc[$];
    logic [N-1:0]  grant_log[$];

    always @(posedge clk_sys) cycle <= cycle + 1;

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (ls_we_req != prev_we) begin
                we_toggles++;
                toggle_cyc.push_back(cycle);
            end
            if (ls_rd_req != prev_rd) begin
                rd_toggles++;
                if (ls_we_req == prev_we) toggle_cyc.push_back(cycle);
            end
            if (ls_we_req != prev_we && ls_rd_req != prev_rd) both_toggles++;
            if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
        end
        prev_we    = ls_we_req;
        prev_rd    = ls_rd_req;
        prev_grant = grant;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        m_we[idx]            = we;
        m_addr[idx*AW +: AW] = addr;
        m_din[idx*DW +: DW]  = din;
        m_req[idx]           = ~m_req[idx];
    endtask

    task automatic waitAck(input int idx, input string tag);
        int n;
        n = 0;
        while (m_ack[idx] != m_req[idx] && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        checkOutput(tag, 64'(m_ack[idx]), 64'(m_req[idx]));
    endtask

    task automatic doReset();
        @(negedge clk_sys);
        #2;
        reset = 1'b1;
        m_req = '0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    // Each masked requester re-toggles as soon as its previous request is acked.
    task automatic runRequesters(input logic [N-1:0] mask, input int count, input string tag);
        int  issued[N];
        bit  all_done;
        for (int i = 0; i < N; i++) issued[i] = 0;
        all_done = 1'b0;
        for (int step = 0; step < 600 && !all_done; step++) begin
            all_done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    if (m_ack[i] == m_req[i]) begin
                        if (issued[i] < count) begin
                            applyStimulus(i, 1'b1, AW'(i * 256 + issued[i]), DW'(32'hA000_0000 + i * 16 + issued[i]));
                            issued[i]++;
                            all_done = 1'b0;
                        end
                    end else begin
                        all_done = 1'b0;
                    end
                end
            end
            if (!all_done) @(negedge clk_sys);
        end
        checkOutput(tag, 64'(all_done), 64'd1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int n;
        int gs;
        int ts;
        int we0;
        int rd0;
        logic [N-1:0] exp3 [6];
        exp3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset state
        repeat (3) @(negedge clk_sys);
        checkOutput("rst_m_ack", 64'(m_ack), 64'd0);
        checkOutput("rst_grant", 64'(grant), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_we_req", 64'(ls_we_req), 64'd0);
        checkOutput("rst_rd_req", 64'(ls_rd_req), 64'd0);
        checkOutput("rst_m_dout", 64'(m_dout), 64'd0);
        checkOutput("rst_ls_addr", 64'(ls_addr), 64'd0);
        checkOutput("rst_ls_din", 64'(ls_din), 64'd0);
        checkOutput("rst_tmo_err", 64'(tmo_err), 64'd0);
        reset = 1'b0;
        @(negedge clk_sys);
        checkOutput("idle_grant", 64'(grant), 64'd0);

        // Requester 0 write, SDRAM acks 5 cycles after the toggle
        lat = 5;
        we0 = we_toggles;
        rd0 = rd_toggles;
        applyStimulus(0, 1'b1, 25'h000_0000, 32'hDEAD_BEEF);
        @(negedge clk_sys);
        checkOutput("t1_grant", 64'(grant), 64'b001);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        checkOutput("t1_we_req_pre", 64'(ls_we_req), 64'd0);
        @(negedge clk_sys);
        checkOutput("t1_we_req", 64'(ls_we_req), 64'd1);
        checkOutput("t1_ls_addr", 64'(ls_addr), 64'd0);
        checkOutput("t1_ls_din", 64'(ls_din), 64'hDEAD_BEEF);
        n = 0;
        while (ls_we_ack != ls_we_req && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        checkOutput("t1_sdram_lat", 64'(n), 64'd5);
        checkOutput("t1_m_ack_early", 64'(m_ack[0]), 64'd0);
        @(negedge clk_sys);
        checkOutput("t1_m_ack", 64'(m_ack[0]), 64'd1);
        checkOutput("t1_busy_done", 64'(busy), 64'd0);
        checkOutput("t1_we_toggles", 64'(we_toggles - we0), 64'd1);
        checkOutput("t1_rd_toggles", 64'(rd_toggles - rd0), 64'd0);

        // Requester 1 read, then m_dout must survive a requester-0 write
        @(negedge clk_sys);
        lat = 3;
        model_rdata = 32'h1234_5678;
        rd0 = rd_toggles;
        applyStimulus(1, 1'b0, 25'h010_0200, 32'h0);
        waitAck(1, "t2_ack1");
        checkOutput("t2_m_dout", 64'(m_dout), 64'h1234_5678);
        checkOutput("t2_ls_addr", 64'(ls_addr), 64'h010_0200);
        checkOutput("t2_rd_toggles", 64'(rd_toggles - rd0), 64'd1);
        model_rdata = 32'hCAFE_F00D;
        @(negedge clk_sys);
        applyStimulus(0, 1'b1, 25'h000_0040, 32'h1111_2222);
        waitAck(0, "t2_ack0");
        checkOutput("t2_m_dout_held", 64'(m_dout), 64'h1234_5678);
        checkOutput("t2_m_ack", 64'(m_ack), 64'b010);
        checkOutput("t2_ls_din", 64'(ls_din), 64'h1111_2222);

        // All three toggle together and re-request on ack: strict rotation
        doReset();
        lat = 1;
        gs = grant_log.size();
        @(negedge clk_sys);
        runRequesters(3'b111, 2, "t3_complete");
        checkOutput("t3_grant_count", 64'(grant_log.size() - gs), 64'd6);
        for (int j = 0; j < 6; j++) begin
            checkOutput($sformatf("t3_grant%0d", j),
                        64'((gs + j < grant_log.size()) ? grant_log[gs + j] : 3'b000), 64'(exp3[j]));
        end

        // Requester 2 alone: toggles spaced by lat + 3 edges (one IDLE cycle)
        lat = 2;
        gs = grant_log.size();
        ts = toggle_cyc.size();
        runRequesters(3'b100, 4, "t4_complete");
        checkOutput("t4_grant_count", 64'(grant_log.size() - gs), 64'd4);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("t4_grant%0d", j),
                        64'((gs + j < grant_log.size()) ? grant_log[gs + j] : 3'b000), 64'b100);
        end
        checkOutput("t4_toggle_count", 64'(toggle_cyc.size() - ts), 64'd4);
        for (int j = 1; j < 4; j++) begin
            checkOutput($sformatf("t4_gap%0d", j),
                        64'((ts + j < toggle_cyc.size()) ? toggle_cyc[ts + j] - toggle_cyc[ts + j - 1] : 0), 64'd5);
        end
        checkOutput("t4_both_toggles", 64'(both_toggles), 64'd0);

        // Asynchronous reset while a read is outstanding
        doReset();
        lat = 40;
        @(negedge clk_sys);
        applyStimulus(1, 1'b0, 25'h000_1234, 32'h0);
        repeat (4) @(negedge clk_sys);
        checkOutput("t5_rd_req", 64'(ls_rd_req), 64'd1);
        checkOutput("t5_busy", 64'(busy), 64'd1);
        checkOutput("t5_grant", 64'(grant), 64'b010);
        #2;
        reset = 1'b1;
        m_req = '0;
        #1;
        checkOutput("t5_async_rd_req", 64'(ls_rd_req), 64'd0);
        checkOutput("t5_async_we_req", 64'(ls_we_req), 64'd0);
        checkOutput("t5_async_busy", 64'(busy), 64'd0);
        checkOutput("t5_async_grant", 64'(grant), 64'd0);
        checkOutput("t5_async_m_ack", 64'(m_ack), 64'd0);
        checkOutput("t5_async_ls_addr", 64'(ls_addr), 64'd0);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        lat = 3;
        model_rdata = 32'h0BAD_CAFE;
        @(negedge clk_sys);
        applyStimulus(1, 1'b0, 25'h000_2000, 32'h0);
        waitAck(1, "t5_ack1");
        checkOutput("t5_m_dout", 64'(m_dout), 64'h0BAD_CAFE);
        checkOutput("t5_m_ack", 64'(m_ack), 64'b010);

`ifdef LS_ARB_WATCHDOG_EN
        // SDRAM never answers: watchdog releases requester 0 and requester 1 is served next
        doReset();
        noack = 1'b1;
        model_rdata = 32'h7777_7777;
        @(negedge clk_sys);
        applyStimulus(0, 1'b0, 25'h000_0300, 32'h0);
        applyStimulus(1, 1'b1, 25'h000_0400, 32'h0000_0055);
        n = 0;
        while (ls_rd_req == 1'b0 && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        checkOutput("t6_rd_req", 64'(ls_rd_req), 64'd1);
        n = 0;
        while (!tmo_err && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        checkOutput("t6_wait_cycles", 64'(n), 64'd15);
        checkOutput("t6_m_ack", 64'(m_ack), 64'b001);
        checkOutput("t6_rd_realign", 64'(ls_rd_req), 64'(ls_rd_ack));
        checkOutput("t6_m_dout", 64'(m_dout), 64'd0);
        noack = 1'b0;
        @(negedge clk_sys);
        checkOutput("t6_next_grant", 64'(grant), 64'b010);
        waitAck(1, "t6_ack1");
        checkOutput("t6_tmo_sticky", 64'(tmo_err), 64'd1);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
